// File: rtl/load_store_unit.sv
// Memory-access stage: issues one load/store per instruction on a req/ack bus,
// aligns/extends load data and stalls the core until the access completes.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        misaligned,
    output logic        access_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] baddr_q, baddr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] bwd_q, bwd_d;
    logic [31:0] ld_q, ld_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;

    logic        op;
    logic        ill;
    logic        mis;
    logic        go;
    logic [1:0]  sz;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [31:0] ld_ext;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Decode the incoming request: size, legality and alignment.
    always_comb begin
        op  = mem_write | mem_read;
        sz  = funct3[1:0];
        ill = 1'b0;
        if (mem_write) begin
            ill = funct3[2] | (funct3[1:0] == 2'b11);
        end else begin
            ill = (funct3 == 3'b011) | (funct3 == 3'b110) |
                  (funct3 == 3'b111);
        end
        mis = ((sz == 2'b01) && addr[0]) ||
              ((sz == 2'b10) && (addr[1:0] != 2'b00));
    end

    assign go = (state_q == S_IDLE) && op && !ill && !mis;

    // Store byte enables and lane-replicated write data.
    always_comb begin
        be_n = 4'b1111;
        wd_n = 32'h0;
        if (mem_write) begin
            unique case (sz)
                2'b00: begin
                    be_n = 4'b0001 << addr[1:0];
                    wd_n = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be_n = addr[1] ? 4'b1100 : 4'b0011;
                    wd_n = {2{wdata[15:0]}};
                end
                default: begin
                    be_n = 4'b1111;
                    wd_n = wdata;
                end
            endcase
        end
    end

    // Select the addressed lane of the read word and extend it.
    always_comb begin
        lane_b = bus_rdata[7:0];
        unique case (off_q)
            2'b00: lane_b = bus_rdata[7:0];
            2'b01: lane_b = bus_rdata[15:8];
            2'b10: lane_b = bus_rdata[23:16];
            2'b11: lane_b = bus_rdata[31:24];
        endcase
        lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (f3_q)
            3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
            3'b100:  ld_ext = {24'h0, lane_b};
            3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
            3'b101:  ld_ext = {16'h0, lane_h};
            default: ld_ext = bus_rdata;
        endcase
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        req_d   = req_q;
        we_d    = we_q;
        baddr_d = baddr_q;
        be_d    = be_q;
        bwd_d   = bwd_q;
        ld_d    = ld_q;
        f3_d    = f3_q;
        off_d   = off_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_BUSY;
                    cnt_d   = 8'd0;
                    fault_d = 1'b0;
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    baddr_d = {addr[31:2], 2'b00};
                    be_d    = be_n;
                    bwd_d   = wd_n;
                    f3_d    = funct3;
                    off_d   = addr[1:0];
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_err) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else if (bus_ack) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    if (!we_q) begin
                        ld_d = ld_ext;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = 8'd0;
                fault_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Core-facing status: stall while a valid request is pending or in flight.
    always_comb begin
        stall        = 1'b0;
        misaligned   = 1'b0;
        access_fault = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                stall        = go;
                misaligned   = op && mis;
                access_fault = op && ill;
            end
            S_BUSY:  stall = 1'b1;
            S_DONE:  access_fault = fault_q;
            default: stall = 1'b0;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            baddr_q <= 32'h0;
            be_q    <= 4'h0;
            bwd_q   <= 32'h0;
            ld_q    <= 32'h0;
            f3_q    <= 3'b0;
            off_q   <= 2'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            req_q   <= req_d;
            we_q    <= we_d;
            baddr_q <= baddr_d;
            be_q    <= be_d;
            bwd_q   <= bwd_d;
            ld_q    <= ld_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end

    assign load_data = ld_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = baddr_q;
    assign bus_be    = be_q;
    assign bus_wdata = bwd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus reset-in-flight
// sequence, run with TIMEOUT=4.
module tb_load_store_unit;

    logic        clk;
    logic        reset_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        stall;
    logic        misaligned;
    logic        access_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    int tests;
    int fails;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .load_data    (load_data),
        .stall        (stall),
        .misaligned   (misaligned),
        .access_fault (access_fault),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err),
        .bus_rdata    (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;
        int          err_at;
        logic        go;
        logic [3:0]  be;
        logic [31:0] bwd;
        int          busy;
        logic        fault;
        logic        mis;
        logic [31:0] ld;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input int idx);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (vec %0d): got %h expected %h",
                     name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rd, input logic wr, input logic [2:0] f3,
        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdt,
        input int ack_at, input int err_at, input logic go,
        input logic [3:0] be, input logic [31:0] bwd, input int busy,
        input logic fault, input logic mis, input logic [31:0] ld);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.rdata = rdt; v.ack_at = ack_at; v.err_at = err_at; v.go = go;
        v.be = be; v.bwd = bwd; v.busy = busy; v.fault = fault;
        v.mis = mis; v.ld = ld;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int  n;
        bit  done;
        logic [31:0] exp_addr;
        exp_addr = {v.addr[31:2], 2'b00};
        @(negedge clk);
        mem_read  = v.rd;
        mem_write = v.wr;
        funct3    = v.f3;
        addr      = v.addr;
        wdata     = v.wdata;
        #1;
        chk("misaligned", 32'(misaligned), 32'(v.mis), idx);
        chk("fault_idle", 32'(access_fault), v.go ? 32'd0 : 32'(v.fault), idx);
        chk("stall_req", 32'(stall), 32'(v.go), idx);
        if (!v.go) begin
            @(posedge clk);
            @(negedge clk);
            chk("no_req", 32'(bus_req), 32'd0, idx);
            chk("no_stall", 32'(stall), 32'd0, idx);
            chk("load_keep", load_data, v.ld, idx);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            return;
        end
        @(posedge clk);
        n    = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            if (n == 0) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
                chk("bus_we", 32'(bus_we), 32'(v.wr), idx);
                chk("bus_be", 32'(bus_be), 32'(v.be), idx);
                if (v.wr) chk("bus_wdata", bus_wdata, v.bwd, idx);
            end
            if (!stall) begin
                done = 1'b1;
            end else begin
                chk("bus_req_busy", 32'(bus_req), 32'd1, idx);
                chk("bus_addr", bus_addr, exp_addr, idx);
                bus_ack   = (n == v.ack_at);
                bus_err   = (n == v.err_at);
                bus_rdata = v.rdata;
                n++;
                @(posedge clk);
            end
        end
        bus_ack = 1'b0;
        bus_err = 1'b0;
        chk("busy_cycles", 32'(n), 32'(v.busy), idx);
        chk("done_fault", 32'(access_fault), 32'(v.fault), idx);
        chk("done_req", 32'(bus_req), 32'd0, idx);
        chk("load_data", load_data, v.ld, idx);
        @(posedge clk);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset_n   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        funct3    = 3'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = 32'h0;

        vecs[0]  = mk(1,0,3'b010,32'h100,0,32'hDEADBEEF,0,-1,1,4'hF,0,1,0,0,32'hDEADBEEF);
        vecs[1]  = mk(1,0,3'b000,32'h203,0,32'h80112233,0,-1,1,4'hF,0,1,0,0,32'hFFFFFF80);
        vecs[2]  = mk(1,0,3'b100,32'h203,0,32'h80112233,0,-1,1,4'hF,0,1,0,0,32'h00000080);
        vecs[3]  = mk(1,0,3'b001,32'h202,0,32'h80112233,0,-1,1,4'hF,0,1,0,0,32'hFFFF8011);
        vecs[4]  = mk(1,0,3'b101,32'h202,0,32'h80112233,0,-1,1,4'hF,0,1,0,0,32'h00008011);
        vecs[5]  = mk(0,1,3'b000,32'h11,32'hA5,0,0,-1,1,4'b0010,32'hA5A5A5A5,1,0,0,32'h00008011);
        vecs[6]  = mk(0,1,3'b001,32'h12,32'h1234,0,0,-1,1,4'b1100,32'h12341234,1,0,0,32'h00008011);
        vecs[7]  = mk(0,1,3'b010,32'h20,32'hCAFEF00D,0,2,-1,1,4'hF,32'hCAFEF00D,3,0,0,32'h00008011);
        vecs[8]  = mk(1,0,3'b010,32'h102,0,0,0,-1,0,4'h0,0,0,0,1,32'h00008011);
        vecs[9]  = mk(1,0,3'b011,32'h100,0,0,0,-1,0,4'h0,0,0,1,0,32'h00008011);
        vecs[10] = mk(1,0,3'b010,32'h300,0,32'h55555555,-1,-1,1,4'hF,0,4,1,0,32'h00008011);
        vecs[11] = mk(1,0,3'b010,32'h304,0,32'h66666666,-1,1,1,4'hF,0,2,1,0,32'h00008011);
        vecs[12] = mk(1,0,3'b000,32'h200,0,32'h0000007F,1,-1,1,4'hF,0,2,0,0,32'h0000007F);
        vecs[13] = mk(0,1,3'b011,32'h8,32'h1,0,0,-1,0,4'h0,0,0,1,0,32'h0000007F);
        vecs[14] = mk(1,1,3'b000,32'h3,32'h5A,0,0,-1,1,4'b1000,32'h5A5A5A5A,1,0,0,32'h0000007F);
        vecs[15] = mk(1,0,3'b010,32'h40,0,32'h11111111,0,0,1,4'hF,0,1,1,0,32'h0000007F);
        vecs[16] = mk(1,0,3'b001,32'h201,0,0,0,-1,0,4'h0,0,0,0,1,32'h0000007F);
        vecs[17] = mk(1,0,3'b101,32'h200,0,32'hABCD9876,0,-1,1,4'hF,0,1,0,0,32'h00009876);
        vecs[18] = mk(0,1,3'b010,32'h22,32'h77,0,0,-1,0,4'h0,0,0,0,1,32'h00009876);
        vecs[19] = mk(1,0,3'b010,32'h44,0,32'h0BADF00D,3,-1,1,4'hF,0,4,0,0,32'h0BADF00D);

        #2;
        chk("rst_req", 32'(bus_req), 32'd0, -1);
        chk("rst_we", 32'(bus_we), 32'd0, -1);
        chk("rst_addr", bus_addr, 32'd0, -1);
        chk("rst_be", 32'(bus_be), 32'd0, -1);
        chk("rst_wdata", bus_wdata, 32'd0, -1);
        chk("rst_load", load_data, 32'd0, -1);
        chk("rst_stall", 32'(stall), 32'd0, -1);
        chk("rst_flags", 32'({misaligned, access_fault}), 32'd0, -1);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset asserted in the second BUSY cycle of a load.
        @(negedge clk);
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h500;
        @(posedge clk);
        @(negedge clk);
        mem_read = 1'b0;
        chk("mid_busy_req", 32'(bus_req), 32'd1, -2);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus_req), 32'd0, -2);
        chk("mid_rst_stall", 32'(stall), 32'd0, -2);
        @(negedge clk);
        reset_n   = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        bus_ack = 1'b0;
        chk("late_ack_load", load_data, 32'd0, -2);
        chk("late_ack_req", 32'(bus_req), 32'd0, -2);
        chk("late_ack_stall", 32'(stall), 32'd0, -2);

        for (int i = 0; i < 20; i++) begin
            run_vec(vecs[i], i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU: the ALU result is the effective address, and rs2 is the store data.
- Issues one load or store per instruction on a simple req/ack data bus.
- Generates byte enables, aligns and extends load data, and stalls the core until the access completes.
- Detects misaligned addresses, illegal funct3 codes, bus errors and bus timeouts.

Parameters:
- TIMEOUT, 255: maximum bus wait cycles in BUSY before the access is aborted with a fault; legal range 1-255.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- mem_read  in  1  load requested by the current instruction
- mem_write  in  1  store requested by the current instruction
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data (rs2)
- load_data  out  32  aligned, extended load result for writeback
- stall  out  1  freezes PC and pipeline inputs while high
- misaligned  out  1  address is not naturally aligned for the access size
- access_fault  out  1  illegal funct3, bus error or timeout
- bus_req  out  1  bus request, held until ack/err
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  access complete; bus_rdata valid in the same cycle
- bus_err  in  1  access failed
- bus_rdata  in  32  read word

Behaviour:
- Reset (async, immediate): state IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, load_data=0, timeout counter=0; stall, misaligned and access_fault all 0. An ack arriving after reset is ignored.
- Request decode (IDLE): op = mem_write|mem_read. If both are high, the store wins.
- Misalignment:
  - H/HU with addr[0]=1, or W with addr[1:0]!=0, sets misaligned=1 combinationally in IDLE.
  - Stores use funct3[1:0] for the size check.
- Illegal funct3: load funct3 011/110/111, or store funct3 other than 000/001/010, sets access_fault=1 combinationally in IDLE.
- Any misaligned or illegal request: no bus access, stall=0, state stays IDLE.
- States:
  - IDLE: a valid op drives stall=1 combinationally. At the clock edge, latch addr, funct3, bus_we, bus_be and bus_wdata; set bus_req=1; go to BUSY.
  - BUSY: stall=1; counter increments each cycle.
    - bus_ack: drop bus_req; on a load, register load_data; go to DONE.
    - bus_err: drop bus_req; go to DONE with fault flagged.
    - Counter reaches TIMEOUT with no ack: drop bus_req; go to DONE with fault flagged.
    - ack and err in the same cycle: err wins.
  - DONE: stall=0 for exactly one cycle; access_fault=1 this cycle if fault was flagged; counter cleared; then IDLE. Requests are not sampled in DONE, because the core advances on this edge.
- Latency: the minimum access is ack in the first BUSY cycle. Stall is then high for 2 cycles (IDLE request cycle plus BUSY), and load_data is valid in the DONE cycle.
- Bus outputs are stable while bus_req=1.
- Byte enables:
  - SB: bus_be = 4'b0001 << addr[1:0]; bus_wdata = {4{wdata[7:0]}}.
  - SH: bus_be = addr[1] ? 1100 : 0011; bus_wdata = {2{wdata[15:0]}}.
  - SW: bus_be = 1111; bus_wdata = wdata.
  - Loads: bus_be = 1111.
- Load data:
  - Byte loads select the lane at addr[1:0]; halfword loads select the half at addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - load_data holds its value until the next successful load; faulted loads and stores leave it unchanged.
- Reset mid-BUSY: bus_req drops immediately and nothing is written to load_data.

Test Plan:
- LW addr=0x100, bus_ack on first BUSY cycle, rdata=0xDEADBEEF -> bus_addr=0x100, bus_be=1111, stall high 2 cycles, load_data=0xDEADBEEF in DONE.
- LB addr=0x203 with rdata=0x80112233 -> 0xFFFFFF80; LBU at the same address -> 0x00000080; LH addr=0x202 -> 0xFFFF8011; LHU -> 0x00008011.
- SB addr=0x11, wdata=0x000000A5 -> bus_we=1, bus_be=0010, bus_wdata=0xA5A5A5A5, bus_addr=0x10. SH addr=0x12, wdata=0x1234 -> bus_be=1100, bus_wdata=0x12341234.
- LW addr=0x102 -> misaligned=1, no bus_req, stall=0. Load funct3=011 -> access_fault=1, no bus_req.
- TIMEOUT=4, no ack -> bus_req high for 4 BUSY cycles, then DONE with access_fault=1 and load_data unchanged. bus_err in 2nd BUSY cycle -> same fault response.
- reset_n low in 2nd BUSY cycle -> bus_req=0 and stall=0 immediately; a bus_ack one cycle later is ignored and load_data stays 0.
